// File: rtl/data_mem_requester.sv
// data_mem_requester: load-side initiator for a fixed-latency data memory.
// Ports: clk/rst; req_* tagged load request (valid/ready); mem_raddr/mem_rdata
// memory read port; resp_* buffered tagged response (valid/ready);
// inflight = reads issued whose data has not yet returned.
module data_mem_requester #(
   parameter int LATENCY    = 100,
   parameter int TAG_W      = 6,
   parameter int RESP_DEPTH = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [14:0]      req_addr,
   input  logic [TAG_W-1:0] req_tag,
   output logic [14:0]      mem_raddr,
   input  logic [15:0]      mem_rdata,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [TAG_W-1:0] resp_tag,
   output logic [15:0]      resp_data,
   output logic [7:0]       inflight
);

   localparam int AW = $clog2(RESP_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [8:0] DEPTH9 = 9'(RESP_DEPTH);

   logic               up;
   logic [LATENCY-1:0] vpipe;
   logic [14:0]        last_addr;

   logic [TAG_W-1:0]   tagq [RESP_DEPTH];
   logic [PW-1:0]      tq_wr;
   logic [PW-1:0]      tq_rd;

   logic [TAG_W+15:0]  fifo [RESP_DEPTH];
   logic [PW-1:0]      f_wr;
   logic [PW-1:0]      f_rd;
   logic [PW-1:0]      f_cnt;

   logic               accept;
   logic               ret;
   logic               pop;
   logic               full;
   logic [8:0]         used;
   logic [TAG_W+15:0]  head;

   // Credits cover both words in flight and words already buffered, so a
   // returning word always has a FIFO slot. "up" keeps req_ready low until
   // the first edge after reset release.
   assign f_cnt     = f_wr - f_rd;
   assign used      = 9'(inflight) + 9'(f_cnt);
   assign req_ready = up && (used < DEPTH9);

   assign accept    = req_valid && req_ready;
   assign mem_raddr = accept ? req_addr : last_addr;

   // The last pipe stage lines up with the word on mem_rdata.
   assign ret  = vpipe[LATENCY-1];

   assign resp_valid = (f_wr != f_rd);
   assign pop        = resp_valid && resp_ready;
   assign full       = (f_wr[AW-1:0] == f_rd[AW-1:0]) &&
                       (f_wr[AW] != f_rd[AW]);

   // Gate the head so stale storage never shows after a reset.
   assign head = resp_valid ? fifo[f_rd[AW-1:0]] : '0;
   assign resp_tag  = head[TAG_W+15:16];
   assign resp_data = head[15:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         up        <= 1'b0;
         vpipe     <= '0;
         last_addr <= '0;
         tq_wr     <= '0;
         tq_rd     <= '0;
         f_wr      <= '0;
         f_rd      <= '0;
         inflight  <= '0;
      end else begin
         up    <= 1'b1;
         vpipe <= {vpipe[LATENCY-2:0], accept};
         if (accept) begin
            last_addr <= req_addr;
            tq_wr     <= tq_wr + PW'(1);
         end
         if (ret) begin
            tq_rd <= tq_rd + PW'(1);
            f_wr  <= f_wr + PW'(1);
         end
         if (pop) begin
            f_rd <= f_rd + PW'(1);
         end
         case ({accept, ret})
            2'b10:   inflight <= inflight + 8'd1;
            2'b01:   inflight <= inflight - 8'd1;
            default: inflight <= inflight;
         endcase
      end
   end

   // Storage arrays carry no reset; pointers define what is valid.
   always_ff @(posedge clk) begin
      if (accept) begin
         tagq[tq_wr[AW-1:0]] <= req_tag;
      end
      if (ret) begin
         fifo[f_wr[AW-1:0]] <= {tagq[tq_rd[AW-1:0]], mem_rdata};
      end
   end

   a_no_overflow: assert property (
      @(posedge clk) disable iff (rst) !(ret && full && !pop)
   );

endmodule

// File: tb/tb_data_mem_requester.sv
// tb_data_mem_requester: scoreboard bench for data_mem_requester.
// Models a 100-cycle memory; a negedge monitor checks responses in order.
module tb_data_mem_requester;

   localparam int L = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [14:0] req_addr = '0;
   logic [5:0]  req_tag = '0;
   logic [14:0] mem_raddr;
   logic [15:0] mem_rdata;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [5:0]  resp_tag;
   logic [15:0] resp_data;
   logic [7:0]  inflight;

   logic [14:0] hist [L];
   logic [14:0] raddr_s;
   logic [21:0] sb [$];
   int          compared = 0;
   int          mismatched = 0;
   int          peak = 0;

   data_mem_requester dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_tag    (req_tag),
      .mem_raddr  (mem_raddr),
      .mem_rdata  (mem_rdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_tag   (resp_tag),
      .resp_data  (resp_data),
      .inflight   (inflight)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mdata(input logic [14:0] a);
      return ({1'b0, a} * 16'd7) ^ 16'hBE9F;
   endfunction

   // Memory: word for the address driven in cycle k appears in cycle k+L.
   always @(negedge clk) raddr_s = mem_raddr;

   always @(posedge clk) begin
      for (int i = L - 1; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= raddr_s;
   end

   assign mem_rdata = mdata(hist[L-1]);

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Scoreboard push on accept, pop/compare on response handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (int'(inflight) > peak) peak = int'(inflight);
         if (req_valid && req_ready)
            sb.push_back({req_tag, mdata(req_addr)});
         if (resp_valid) begin
            if (sb.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL stale_resp: got tag %0d data %h want none",
                        resp_tag, resp_data);
            end else if (resp_ready) begin
               chk("resp", {10'd0, resp_tag, resp_data}, {10'd0, sb.pop_front()});
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue1(input logic [14:0] a, input logic [5:0] t);
      int n = 0;
      req_valid = 1'b1;
      req_addr  = a;
      req_tag   = t;
      @(negedge clk);
      while (!req_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("issue_timeout", 0, 1);
      step();
      req_valid = 1'b0;
   endtask

   task automatic lat_check(input logic [14:0] a, input logic [5:0] t,
                            input logic [15:0] d);
      int lat = 1;
      issue1(a, t);
      @(negedge clk);
      while (!resp_valid && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, 101);
      chk("lat_tag", resp_tag, t);
      chk("lat_data", resp_data, d);
   endtask

   task automatic drain(input int bound);
      int n = 0;
      resp_ready = 1'b1;
      while (sb.size() != 0 && n < bound) begin
         step();
         n++;
      end
      chk("drain_done", sb.size() == 0, 1);
      step();
      step();
      chk("drain_valid", resp_valid, 0);
      chk("drain_inflight", inflight, 0);
   endtask

   initial begin
      int n;
      int cyc;
      rst = 1'b1;
      repeat (3) step();
      chk("rst_ready", req_ready, 0);
      chk("rst_valid", resp_valid, 0);
      chk("rst_inflight", inflight, 0);
      chk("rst_raddr", mem_raddr, 0);
      chk("rst_tag", resp_tag, 0);
      chk("rst_data", resp_data, 0);
      rst = 1'b0;
      #1;
      chk("rel_ready0", req_ready, 0);
      step();
      chk("rel_ready1", req_ready, 1);

      // 1: single load latency
      resp_ready = 1'b1;
      lat_check(15'h0010, 6'd5, 16'hBEEF);
      step();

      // 2: back-to-back 100 loads
      peak = 0;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         req_valid = 1'b1;
         req_addr  = 15'(i);
         req_tag   = 6'(i % 64);
         @(negedge clk);
         if (!req_ready) n++;
         step();
      end
      req_valid = 1'b0;
      chk("t2_ready_drops", n, 0);
      cyc = 0;
      @(negedge clk);
      while (!resp_valid && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      n = 1;
      for (int i = 0; i < 99; i++) begin
         @(negedge clk);
         if (resp_valid) n++;
      end
      chk("t2_consec", n, 100);
      @(negedge clk);
      chk("t2_end", resp_valid, 0);
      chk("t2_peak", peak, 100);
      drain(50);

      // 3: backpressure up to credit limit
      resp_ready = 1'b0;
      n = 0;
      req_valid = 1'b1;
      req_addr  = 15'h100;
      req_tag   = 6'd0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!req_ready) break;
         n++;
         step();
         req_addr = 15'(32'h100 + n);
         req_tag  = 6'(n % 64);
      end
      req_valid = 1'b0;
      chk("t3_accepted", n, 128);
      repeat (110) step();
      chk("t3_inflight", inflight, 0);
      chk("t3_full_ready", req_ready, 0);
      chk("t3_valid", resp_valid, 1);
      resp_ready = 1'b1;
      @(negedge clk);
      chk("t3_ready_pre", req_ready, 0);
      step();
      resp_ready = 1'b0;
      @(negedge clk);
      chk("t3_ready_post", req_ready, 1);
      step();
      drain(300);

      // 4: accept, return and pop in one cycle
      resp_ready = 1'b1;
      req_valid = 1'b1;
      req_addr  = 15'h40;
      req_tag   = 6'd10;
      step();
      req_addr  = 15'h41;
      req_tag   = 6'd11;
      step();
      req_valid = 1'b0;
      repeat (98) step();
      @(negedge clk);
      chk("t4_pre_infl", inflight, 2);
      chk("t4_pre_valid", resp_valid, 0);
      step();
      req_valid = 1'b1;
      req_addr  = 15'h42;
      req_tag   = 6'd12;
      @(negedge clk);
      chk("t4_mid_infl", inflight, 1);
      chk("t4_mid_valid", resp_valid, 1);
      chk("t4_mid_ready", req_ready, 1);
      step();
      req_valid = 1'b0;
      @(negedge clk);
      chk("t4_post_infl", inflight, 1);
      chk("t4_post_valid", resp_valid, 1);
      step();
      drain(200);

      // 5: reset mid-operation
      resp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1;
         req_addr  = 15'(32'h200 + i);
         req_tag   = 6'(20 + i);
         step();
      end
      req_valid = 1'b0;
      repeat (102) step();
      chk("t5_queued", resp_valid, 1);
      for (int i = 0; i < 40; i++) begin
         req_valid = 1'b1;
         req_addr  = 15'(32'h300 + i);
         req_tag   = 6'((23 + i) % 64);
         step();
      end
      req_valid = 1'b0;
      repeat (5) step();
      @(negedge clk);
      chk("t5_inflight40", inflight, 40);
      step();
      rst = 1'b1;
      sb.delete();
      #1;
      chk("t5_ready", req_ready, 0);
      chk("t5_valid", resp_valid, 0);
      chk("t5_inflight", inflight, 0);
      chk("t5_raddr", mem_raddr, 0);
      chk("t5_tag", resp_tag, 0);
      chk("t5_data", resp_data, 0);
      step();
      step();
      rst = 1'b0;
      #1;
      chk("t5_rel_ready", req_ready, 0);
      resp_ready = 1'b1;
      lat_check(15'h0555, 6'd33, 16'h9BCC);
      repeat (110) step();
      chk("t5_quiet", resp_valid, 0);

      // 6: long run with random consumer stalls
      n = 0;
      cyc = 0;
      while (n < 300 && cyc < 5000) begin
         resp_ready = ($urandom_range(0, 3) != 0);
         req_valid  = 1'b1;
         req_addr   = 15'(n * 37 + 3);
         req_tag    = 6'(n % 64);
         @(negedge clk);
         if (req_ready) n++;
         step();
         cyc++;
      end
      req_valid = 1'b0;
      chk("t6_accepted", n, 300);
      drain(600);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
